// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants and types for the receive and transmit sides.
//   ClksPerBitDef : default clock cycles per bit (50 MHz clock, 38400 baud)
//   HalfBitDef    : default cycles from start edge to the start-bit mid-sample
//   FrameBits     : start + 8 data + stop
//   CntW          : width of the per-bit cycle counter
//   rx_state_t    : receiver FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned ClksPerBitDef = 1302;
    localparam int unsigned HalfBitDef    = 651;
    localparam int unsigned FrameBits     = 10;
    localparam int unsigned DataBits      = FrameBits - 2;
    localparam int unsigned CntW          = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // True when the cycle counter has reached its terminal value.
    function automatic logic count_done(input logic [CntW-1:0] cnt,
                                        input logic [CntW-1:0] last);
        return (cnt == last);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// -----------------------------------------------------------------------------
// rx_sync
// Two-flop synchronizer for the asynchronous serial input. Both flops reset
// to 1 so a reset never looks like a start edge on the idle-high line.
// Ports:
//   Enable   in  clock
//   Reset    in  asynchronous active-high reset
//   async_in in  asynchronous serial line
//   sync_out out synchronized copy of async_in (2-cycle latency)
// -----------------------------------------------------------------------------
module rx_sync (
    input  logic Enable,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    // Two-stage synchronizer chain.
    always_ff @(posedge Enable or posedge Reset) begin
        if (Reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver, LSB first, idle-high line.
// Ports:
//   Enable     in  clock (rising edge)
//   Reset      in  asynchronous active-high reset
//   RxD        in  serial line, asynchronous to Enable
//   ReadAck    in  one-cycle pulse, clears DataValid and Overrun
//   RxData     out last good received byte
//   DataValid  out high while RxData holds an unread byte
//   Overrun    out sticky; a byte completed while DataValid was already high
//   FramingErr out one-cycle pulse when the sampled stop bit is 0
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = ClksPerBitDef,
    parameter int unsigned HalfBit    = HalfBitDef
) (
    input  logic                Enable,
    input  logic                Reset,
    input  logic                RxD,
    input  logic                ReadAck,
    output logic [DataBits-1:0] RxData,
    output logic                DataValid,
    output logic                Overrun,
    output logic                FramingErr
);

    localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);

    logic rxs;

    rx_state_t           state_q,       state_d;
    logic [CntW-1:0]     cnt_q,         cnt_d;
    logic [2:0]          bit_idx_q,     bit_idx_d;
    logic [DataBits-1:0] shift_q,       shift_d;
    logic [DataBits-1:0] rx_data_q,     rx_data_d;
    logic                data_valid_q,  data_valid_d;
    logic                overrun_q,     overrun_d;
    logic                framing_err_q, framing_err_d;

    rx_sync u_rx_sync (
        .Enable   (Enable),
        .Reset    (Reset),
        .async_in (RxD),
        .sync_out (rxs)
    );

    // Next-state and output computation for the receive FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 11'd1;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        framing_err_d = 1'b0;

        // Acknowledge is applied first so a byte completing in the same
        // cycle wins: it sets DataValid again without raising Overrun.
        if (ReadAck) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
            overrun_d    = overrun_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d   = START;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (count_done(cnt_q, HalfLast)) begin
                    cnt_d = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (count_done(cnt_q, BitLast)) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rxs;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (count_done(cnt_q, BitLast)) begin
                    cnt_d = '0;
                    if (rxs) begin
                        rx_data_d    = shift_q;
                        data_valid_d = 1'b1;
                        if (data_valid_q && !ReadAck) begin
                            overrun_d = 1'b1;
                        end else begin
                            overrun_d = overrun_d;
                        end
                        state_d = IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = BREAK;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            BREAK: begin
                // Wait for the line to return high so a held-low line
                // reports only one framing error.
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Enable or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            data_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            data_valid_q  <= data_valid_d;
            overrun_q     <= overrun_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign RxData     = rx_data_q;
    assign DataValid  = data_valid_q;
    assign Overrun    = overrun_q;
    assign FramingErr = framing_err_q;

endmodule
